// File: rtl/lcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_pkg : shared states, LCD command codes and default timing constants
// Rev 1.0
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int DEF_T_SETUP     = 2;
  localparam int DEF_T_EPW       = 12;
  localparam int DEF_T_HOLD      = 2;
  localparam int DEF_T_EXEC      = 2000;
  localparam int DEF_T_EXEC_LONG = 82000;
  localparam int DEF_CNT_W       = 17;

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long delay.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b[7:1] == CMD_CLEAR[7:1]) || (b[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_bus_arbiter_if : requester handshakes plus LCD pin bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface lcd_bus_arbiter_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       done0;
  logic       done1;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;

  modport arb (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, done0, done1, busy, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  modport host (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, done0, done1, busy, lcd_rs, lcd_rw, lcd_e, lcd_db
  );
endinterface
`default_nettype wire

// File: rtl/lcd_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_rr_arb2 : 2-way round-robin arbiter with last-served register
// Rev 1.0
// ---------------------------------------------------------------------------
module lcd_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant,
  output logic winner
);

  logic last;

  always_comb begin
    grant  = req0 | req1;
    winner = (req0 && req1) ? ~last : req1;
  end

  // Reset to 1 so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= winner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_bus_arbiter : shares the HD44780 write bus between two byte requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_EPW       = DEF_T_EPW,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_EXEC      = DEF_T_EXEC,
  parameter int T_EXEC_LONG = DEF_T_EXEC_LONG,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_bus_arbiter_if.arb    bus
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             owner;
  logic             rs_q;
  logic [7:0]       db_q;
  logic             ack_q;
  logic             grant;
  logic             winner;
  logic             take;
  logic             cnt_zero;
  logic [CNT_W-1:0] exec_load;

  assign take     = (state == ST_IDLE) && grant;
  assign cnt_zero = (cnt == '0);
  assign exec_load = is_long_cmd(rs_q, db_q) ? CNT_W'(T_EXEC_LONG - 1)
                                             : CNT_W'(T_EXEC - 1);

  lcd_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (bus.req0),
    .req1   (bus.req1),
    .update (take),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = CNT_W'(T_EPW - 1);
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(T_HOLD - 1);
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = exec_load;
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      rs_q  <= 1'b0;
      db_q  <= 8'h00;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // ack_q marks the first SETUP cycle of a freshly latched transfer.
      ack_q <= take;
      if (take) begin
        owner <= winner;
        rs_q  <= winner ? bus.rs1   : bus.rs0;
        db_q  <= winner ? bus.data1 : bus.data0;
      end
    end
  end

  logic done_w;
  assign done_w = (state == ST_WAIT) && cnt_zero;

  assign bus.ack0   = ack_q & ~owner;
  assign bus.ack1   = ack_q &  owner;
  assign bus.done0  = done_w & ~owner;
  assign bus.done1  = done_w &  owner;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.lcd_e  = (state == ST_PULSE);
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_rs = rs_q;
  assign bus.lcd_db = db_q;

endmodule
`default_nettype wire
